// File: rtl/rand_range_mapper.sv
// rand_range_mapper: maps each new 8-bit random sample uniformly onto [0, RANGE-1]
// via rejection plus iterative subtraction, buffering results in a small FIFO.
// Optional macro RAND_DROP_CNT_EN builds the saturating Drop_Cnt counter.
module rand_range_mapper #(
    parameter int unsigned RANGE = 6,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       Rand_In,
    input  logic             Out_Ready,
    output logic             Out_Valid,
    output logic [OUT_W-1:0] Out_Data,
    output logic [4:0]       Count,
    output logic [7:0]       Drop_Cnt
);

    localparam int unsigned ACC_W = 9;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ACC_W-1:0] LIMIT   = ACC_W'((256 / RANGE) * RANGE);
    localparam logic [ACC_W-1:0] RANGE_V = ACC_W'(RANGE);
    localparam logic [4:0]       DEPTH_V = 5'(DEPTH);

    if (RANGE < 2 || RANGE > 256) begin : g_bad_range
        $error("rand_range_mapper: RANGE must be within 2..256");
    end
    if ((1 << OUT_W) < RANGE) begin : g_bad_out_w
        $error("rand_range_mapper: OUT_W too narrow for RANGE");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rand_range_mapper: DEPTH must be a power of two within 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_PUSH   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         prev_q, prev_d;
    logic               primed_q, primed_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   mem_q [DEPTH];
    logic [OUT_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]         count_q, count_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   data_q, data_d;

    logic               new_sample_c;
    logic               pop_c;
    logic               full_c;
    logic               push_c;
    logic               result_drop_c;
    logic               busy_drop_c;
    logic [OUT_W-1:0]   wdata_c;

    // Sample edge detection; the first value after reset only primes prev_q.
    always_comb begin
        prev_d       = Rand_In;
        primed_d     = 1'b1;
        new_sample_c = primed_q && (Rand_In != prev_q);
    end

    // Mapping FSM: capture, subtract RANGE until below it, then push.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        push_c        = 1'b0;
        result_drop_c = 1'b0;
        busy_drop_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (new_sample_c && ({1'b0, Rand_In} < LIMIT)) begin
                    acc_d   = {1'b0, Rand_In};
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                busy_drop_c = new_sample_c;
                if (acc_q >= RANGE_V) begin
                    acc_d = acc_q - RANGE_V;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                busy_drop_c = new_sample_c;
                if (!full_c || pop_c) begin
                    push_c = 1'b1;
                end else begin
                    result_drop_c = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; the head is re-registered so Out_Data holds when empty.
    always_comb begin
        pop_c    = valid_q && Out_Ready;
        full_c   = (count_q == DEPTH_V);
        wdata_c  = acc_q[OUT_W-1:0];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = wdata_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + 5'(push_c) - 5'(pop_c);
        valid_d = (count_d != 5'd0);
        if (count_d != 5'd0) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                data_d = wdata_c;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        if (rst) begin
            state_q  <= S_IDLE;
            primed_q <= 1'b0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            primed_q <= primed_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            mem_q    <= mem_d;
        end
    end

`ifdef RAND_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic [8:0] drop_sum_c;

    // A busy drop and a full-FIFO drop can coincide; saturate at 255.
    always_comb begin
        drop_sum_c = {1'b0, drop_q} + 9'(busy_drop_c) + 9'(result_drop_c);
        drop_d     = (drop_sum_c > 9'd255) ? 8'd255 : drop_sum_c[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign Drop_Cnt = drop_q;
`else
    logic unused_drop_c;
    assign unused_drop_c = busy_drop_c ^ result_drop_c;
    assign Drop_Cnt      = 8'h00;
`endif

    assign Out_Valid = valid_q;
    assign Out_Data  = data_q;
    assign Count     = count_q;

endmodule
